// File: rtl/fp16_div_mant_iter.sv
// FP16 mantissa divider back-end: restoring divide, one quotient bit per
// cycle, then normalize and pack the half-precision result behind a
// valid/ready handshake. Exception codes from the front-end bypass the
// iteration and produce Inf or signed zero directly.
module fp16_div_mant_iter #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int QBITS  = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [EXP_W-1:0]        io_exp_in,
  input  logic [MANT_W-1:0]       io_mant1,
  input  logic [MANT_W-1:0]       io_mant2,
  input  logic                    io_sign,
  input  logic [1:0]              io_except_code,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [EXP_W+MANT_W:0]   io_result,
  output logic [1:0]              io_flags
);

  localparam int CNT_W = $clog2(QBITS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [MANT_W+1:0] rem;
  logic [MANT_W:0]   div_b;
  logic [QBITS-1:0]  q;
  logic [CNT_W-1:0]  cnt;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;

  logic              accept;
  logic              last_iter;
  logic              ge;
  logic [MANT_W+1:0] rem_sub;
  logic [MANT_W+1:0] rem_next;
  logic [QBITS-1:0]  q_next;
  logic [MANT_W-1:0] norm_mant;
  logic [EXP_W-1:0]  norm_exp;
  logic              norm_uf;
  logic              norm_of;

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign accept       = io_in_valid && io_in_ready;
  assign last_iter    = (cnt == CNT_W'(QBITS - 1));

  // One restoring-divide step plus normalization of the resulting quotient
  always_comb begin
    ge       = (rem >= {1'b0, div_b});
    rem_sub  = ge ? (rem - {1'b0, div_b}) : rem;
    rem_next = {rem_sub[MANT_W:0], 1'b0};
    q_next   = {q[QBITS-2:0], ge};
    norm_uf  = 1'b0;
    if (q_next[QBITS-1]) begin
      norm_mant = q_next[QBITS-2 -: MANT_W];
      norm_exp  = exp_r;
    end else begin
      norm_mant = q_next[MANT_W-1:0];
      norm_exp  = exp_r - 1'b1;
      norm_uf   = (exp_r == '0);
    end
    norm_of = (norm_exp == '1) && !norm_uf;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (io_except_code == 2'd0) ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (io_out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result packing
  always_ff @(posedge clock) begin
    if (reset) begin
      rem       <= '0;
      div_b     <= '0;
      q         <= '0;
      cnt       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      io_result <= '0;
      io_flags  <= 2'd0;
    end else begin
      if (accept) begin
        rem    <= {2'b01, io_mant1};
        div_b  <= {1'b1, io_mant2};
        q      <= '0;
        cnt    <= '0;
        exp_r  <= io_exp_in;
        sign_r <= io_sign;
        if (io_except_code == 2'd1) begin
          io_result <= {io_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          io_flags  <= 2'd1;
        end else if (io_except_code != 2'd0) begin
          io_result <= {io_sign, {(EXP_W+MANT_W){1'b0}}};
          io_flags  <= 2'd2;
        end
      end else if (state == BUSY) begin
        rem <= rem_next;
        q   <= q_next;
        cnt <= cnt + 1'b1;
        if (last_iter) begin
          if (norm_uf) begin
            io_result <= {sign_r, {(EXP_W+MANT_W){1'b0}}};
            io_flags  <= 2'd2;
          end else if (norm_of) begin
            io_result <= {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            io_flags  <= 2'd1;
          end else begin
            io_result <= {sign_r, norm_exp, norm_mant};
            io_flags  <= 2'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_div_mant_iter.sv
// Directed bench for fp16_div_mant_iter: hand-computed quotients, exception
// bypass, normalization boundaries, backpressure and mid-operation reset.
module tb_fp16_div_mant_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [4:0]  io_exp_in;
  logic [9:0]  io_mant1;
  logic [9:0]  io_mant2;
  logic        io_sign;
  logic [1:0]  io_except_code;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_result;
  logic [1:0]  io_flags;

  int checks = 0;
  int errors = 0;
  int lat;

  fp16_div_mant_iter #(.MANT_W(10), .EXP_W(5), .QBITS(12)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_exp_in      (io_exp_in),
    .io_mant1       (io_mant1),
    .io_mant2       (io_mant2),
    .io_sign        (io_sign),
    .io_except_code (io_except_code),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_result      (io_result),
    .io_flags       (io_flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present one operand bundle, then count rising edges (accept edge = 1)
  // until io_out_valid is seen; operands are scrambled after accept.
  task automatic issue(input logic [4:0] e, input logic [9:0] m1, input logic [9:0] m2,
                       input logic s, input logic [1:0] x, output int edges);
    @(negedge clock);
    io_exp_in = e; io_mant1 = m1; io_mant2 = m2; io_sign = s; io_except_code = x;
    io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    io_exp_in = ~e; io_mant1 = ~m1; io_mant2 = ~m2; io_sign = ~s; io_except_code = 2'd0;
    edges = 1;
    while (!io_out_valid && edges < 40) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clock);
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 16'(io_out_valid), 16'h0);
    chk({tag, "_ready_back"}, 16'(io_in_ready), 16'h1);
  endtask

  task automatic op(input string tag, input logic [4:0] e, input logic [9:0] m1,
                    input logic [9:0] m2, input logic s, input logic [1:0] x,
                    input logic [15:0] exp_res, input logic [1:0] exp_flg, input int exp_lat);
    int n;
    chk({tag, "_ready_pre"}, 16'(io_in_ready), 16'h1);
    issue(e, m1, m2, s, x, n);
    chk({tag, "_latency"}, 16'(n), 16'(exp_lat));
    chk({tag, "_result"}, io_result, exp_res);
    chk({tag, "_flags"}, 16'(io_flags), 16'(exp_flg));
    chk({tag, "_ready_done"}, 16'(io_in_ready), 16'h0);
    release_out(tag);
  endtask

  initial begin
    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_exp_in = '0; io_mant1 = '0; io_mant2 = '0; io_sign = 1'b0; io_except_code = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 16'(io_out_valid), 16'h0);
    chk("rst_result", io_result, 16'h0000);
    chk("rst_flags", 16'(io_flags), 16'h0);
    chk("rst_ready", 16'(io_in_ready), 16'h1);
    @(negedge clock); reset = 1'b0;

    op("one_by_one",   5'd15, 10'h000, 10'h000, 1'b0, 2'd0, 16'h3C00, 2'd0, 13);
    op("1p5_by_one",   5'd15, 10'h200, 10'h000, 1'b0, 2'd0, 16'h3E00, 2'd0, 13);
    op("one_by_1p5",   5'd15, 10'h000, 10'h200, 1'b0, 2'd0, 16'h3955, 2'd0, 13);
    op("max_by_one",   5'd20, 10'h3FF, 10'h000, 1'b1, 2'd0, 16'hD3FF, 2'd0, 13);
    op("exc_ovf",      5'd7,  10'h123, 10'h045, 1'b1, 2'd1, 16'hFC00, 2'd1, 1);
    op("exc_unf",      5'd7,  10'h123, 10'h045, 1'b0, 2'd2, 16'h0000, 2'd2, 1);
    op("exc_code3",    5'd7,  10'h123, 10'h045, 1'b1, 2'd3, 16'h8000, 2'd2, 1);
    op("norm_unf",     5'd0,  10'h000, 10'h200, 1'b0, 2'd0, 16'h0000, 2'd2, 13);
    op("exp0_no_unf",  5'd0,  10'h200, 10'h000, 1'b0, 2'd0, 16'h0200, 2'd0, 13);
    op("norm_ovf",     5'd31, 10'h200, 10'h000, 1'b0, 2'd0, 16'h7C00, 2'd1, 13);
    op("exp31_to_30",  5'd31, 10'h000, 10'h200, 1'b0, 2'd0, 16'h7955, 2'd0, 13);

    // Backpressure: result held while downstream stalls; a pending upstream
    // request must not be accepted.
    issue(5'd15, 10'h200, 10'h000, 1'b0, 2'd0, lat);
    chk("bp_latency", 16'(lat), 16'd13);
    @(negedge clock); io_in_valid = 1'b1; io_except_code = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_result", io_result, 16'h3E00);
      chk("bp_valid", 16'(io_out_valid), 16'h1);
      chk("bp_ready", 16'(io_in_ready), 16'h0);
    end
    @(negedge clock); io_in_valid = 1'b0; io_except_code = 2'd0;
    release_out("bp");

    // Reset during iteration 5 aborts the operation.
    @(negedge clock);
    io_exp_in = 5'd15; io_mant1 = 10'h000; io_mant2 = 10'h200; io_sign = 1'b0;
    io_except_code = 2'd0; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_valid", 16'(io_out_valid), 16'h0);
    chk("abort_ready", 16'(io_in_ready), 16'h1);
    @(negedge clock); reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (io_out_valid) lat++;
    end
    chk("abort_no_output", 16'(lat), 16'h0);

    op("after_abort",  5'd15, 10'h000, 10'h200, 1'b1, 2'd0, 16'hB955, 2'd0, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
